change_dispenser: RTL and testbench
===================================

# change_dispenser

Return-path counterpart of the vending machine's coin acceptor. The coin front end turns `m`/`a` coin events into 3-bit credit; this block turns a 3-bit credit amount back into a sequence of physical coin requests to a coin hopper. It uses greedy denominations (`a` coin = 2 credits, `m` coin = 1 credit) and a req/ack handshake per coin. It sits beside the Moore/Mealy pair, on the same prescaled clock, and is triggered by the refund/change request.

## Interface
- `GAP_CYCLES`, default 4: idle cycles inserted between consecutive coin requests (0..255).
- `ACK_TIMEOUT`, default 255: REQ cycles without `hopper_ack` before fault (1..255). Used only with `CHANGE_TIMEOUT_EN`.
- `clk`  in  1: clock; single clock domain; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; overrides every other input.
- `refund`  in  1: start request; sampled only in IDLE.
- `amount`  in  3: credit to return; latched when `refund` is accepted.
- `hopper_ack`  in  1: hopper accepted the current coin; meaningful only while a coin request is high.
- `coin_a`  out  1: request one 2-credit coin; held until acked.
- `coin_m`  out  1: request one 1-credit coin; held until acked.
- `busy`  out  1: a change sequence is in progress.
- `done`  out  1: one-cycle pulse at the end of a sequence.
- `remaining`  out  3: credit not yet dispensed.
- `err`  out  1: sticky hopper-timeout fault.

## Operation
- States: IDLE, REQ, GAP, DONE, ERR. All outputs are registered.
- Reset: state IDLE. `coin_a`, `coin_m`, `busy`, `done`, `err` = 0. `remaining` = 0. Gap and timeout counters cleared. A sequence in progress is abandoned immediately; no coin request survives reset.
- IDLE:
  - `refund`=1 and `amount`≠0: latch `remaining`←`amount` and go to REQ.
  - `refund`=1 and `amount`=0: go to DONE; no coin is requested.
  - Otherwise stay in IDLE. `hopper_ack` is ignored.
- Entering REQ: if `remaining`≥2 assert `coin_a`, else assert `coin_m`. Exactly one coin output is high at a time. The denomination is fixed for the whole request.
- REQ with `hopper_ack`=1: subtract the coin value (2 or 1) from `remaining` and drop the coin output on the next edge. Go to GAP if the new `remaining`≠0, else go to DONE.
- GAP: coin outputs low for `GAP_CYCLES` cycles, then go to REQ. With `GAP_CYCLES`=0, REQ is re-entered directly, but the coin output is still low for at least 1 cycle between coins.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE.
- `busy`=1 in REQ and GAP only.
- Greedy order: `a` coins first, then at most one `m` coin. Examples: 7 → a,a,a,m; 5 → a,a,m; 1 → m.
- `refund` while `busy`=1, in DONE, or in ERR: ignored; `amount` is not re-latched.
- `hopper_ack` outside REQ: ignored. `hopper_ack` held high across a gap counts once per REQ entry, on the first REQ cycle.

## Timing
- `refund` sampled at edge N: `busy` and the coin output are high after edge N+1.
- `hopper_ack` sampled high at edge K: the coin output is low and `remaining` is updated after edge K+1.
- With constant `hopper_ack`=1: each coin takes 1 REQ cycle plus `GAP_CYCLES` gap cycles, and `done` follows the last ack by one cycle.
- Total sequence length with constant ack: coins×(1+`GAP_CYCLES`) − `GAP_CYCLES` cycles from the first coin request to the last ack. `done` is high on the cycle after the last ack.
- `refund` with `amount`=0 at edge N: `done` is high after edge N+1.

## Configuration
- `CHANGE_TIMEOUT_EN` defined:
  - An 8-bit counter runs in REQ and clears on REQ entry.
  - After `ACK_TIMEOUT` REQ cycles without ack, go to ERR.
  - ERR: coin outputs 0, `busy`=0, `err`=1, `remaining` frozen at its last value. ERR exits only via `reset`.
- `CHANGE_TIMEOUT_EN` undefined:
  - No counter and no ERR state; REQ waits for ack indefinitely.
  - `err` tied to 0.

## Test plan
- Reset, then `amount`=5, `refund` pulse, `hopper_ack` tied 1, `GAP_CYCLES`=4 → coin pulses a, a, m, each 1 cycle wide and 5 cycles apart. `remaining` goes 5→3→1→0. `done` 1 cycle after the m coin. `busy` low with `done`.
- `amount`=0, `refund` → `done` the next cycle; `coin_a`/`coin_m`/`busy` never assert.
- `amount`=1, ack returned 3 cycles after `coin_m` rises → `coin_m` held exactly 4 cycles, then `done`. A second `refund` with `amount`=7 during `busy` is ignored.
- `amount`=7 mid-sequence (after the second a coin), assert `reset` 1 cycle → all outputs 0 next cycle. A following `refund` with `amount`=2 yields a single a coin.
- `CHANGE_TIMEOUT_EN`, `ACK_TIMEOUT`=10, `amount`=3, no ack → `coin_a` high 10 cycles, then `err`=1, coin low, `remaining`=3. Later `refund`/ack have no effect until `reset`.
- Without `CHANGE_TIMEOUT_EN`, same stimulus for 300 cycles → `coin_a` stays high, `err`=0. Ack at cycle 300 resumes with an m coin.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Hopper-side bundle for change_dispenser: refund request, hopper ack and coin requests.
// The master drives requests and acks; the slave (the dispenser) drives coins and status.
interface change_dispenser_if;
    logic       refund;
    logic [2:0] amount;
    logic       hopper_ack;
    logic       coin_a;
    logic       coin_m;
    logic       busy;
    logic       done;
    logic [2:0] remaining;
    logic       err;

    modport master (
        output refund, amount, hopper_ack,
        input  coin_a, coin_m, busy, done, remaining, err
    );

    modport slave (
        input  refund, amount, hopper_ack,
        output coin_a, coin_m, busy, done, remaining, err
    );
endinterface

// File: rtl/change_dispenser.sv
// Converts a 3-bit credit into greedy a (2) / m (1) coin requests with a req/ack hopper handshake.
// Optional hopper ack timeout with sticky err is enabled by defining CHANGE_TIMEOUT_EN.
module change_dispenser #(
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    change_dispenser_if.slave  bus
);

    // A zero gap still forces one low cycle between coins.
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP,
        ST_DONE
`ifdef CHANGE_TIMEOUT_EN
        , ST_ERR
`endif
    } state_t;

    state_t     state_q;
    logic       refund_q;
    logic [2:0] amount_q;
    logic       ack_q;
    logic [2:0] remaining_q;
    logic       coin_a_q;
    logic       coin_m_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] gap_cnt_q;

    logic [2:0] coin_val;
    logic [2:0] rem_after;

    assign coin_val  = coin_a_q ? 3'd2 : 3'd1;
    assign rem_after = remaining_q - coin_val;

`ifdef CHANGE_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    logic [7:0] to_cnt_q;
    logic       err_q;

    assign bus.err = err_q;
`else
    // Timeout length has no meaning without the timeout logic.
    logic [7:0] unused_ack_timeout;
    assign unused_ack_timeout = 8'(ACK_TIMEOUT);

    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            refund_q    <= 1'b0;
            amount_q    <= 3'd0;
            ack_q       <= 1'b0;
            remaining_q <= 3'd0;
            coin_a_q    <= 1'b0;
            coin_m_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gap_cnt_q   <= 8'd0;
`ifdef CHANGE_TIMEOUT_EN
            to_cnt_q    <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            // Refund only registers while idle, so a request seen in DONE cannot start a new run.
            refund_q <= bus.refund && (state_q == ST_IDLE);
            amount_q <= bus.amount;
            ack_q    <= bus.hopper_ack;
            done_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (refund_q) begin
                        if (amount_q != 3'd0) begin
                            remaining_q <= amount_q;
                            coin_a_q    <= (amount_q >= 3'd2);
                            coin_m_q    <= (amount_q < 3'd2);
                            busy_q      <= 1'b1;
                            state_q     <= ST_REQ;
`ifdef CHANGE_TIMEOUT_EN
                            to_cnt_q    <= 8'd0;
`endif
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end

                ST_REQ: begin
                    if (ack_q) begin
                        remaining_q <= rem_after;
                        coin_a_q    <= 1'b0;
                        coin_m_q    <= 1'b0;
                        gap_cnt_q   <= 8'd0;
                        if (rem_after != 3'd0) begin
                            state_q <= ST_GAP;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
`ifdef CHANGE_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        coin_a_q <= 1'b0;
                        coin_m_q <= 1'b0;
                        busy_q   <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= ST_ERR;
                    end else begin
                        to_cnt_q <= to_cnt_q + 8'd1;
                    end
`endif
                end

                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        coin_a_q <= (remaining_q >= 3'd2);
                        coin_m_q <= (remaining_q < 3'd2);
                        state_q  <= ST_REQ;
`ifdef CHANGE_TIMEOUT_EN
                        to_cnt_q <= 8'd0;
`endif
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 8'd1;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

`ifdef CHANGE_TIMEOUT_EN
                ST_ERR: begin
                    state_q <= ST_ERR;
                end
`endif

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.coin_a    = coin_a_q;
    assign bus.coin_m    = coin_m_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed and randomized bench for change_dispenser; expected coin sequence and timing
// come from the greedy change rule and handshake latencies, computed arithmetically here.
module tb_change_dispenser;

    localparam int GAP = 4;
    localparam int TO  = 10;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    change_dispenser_if bus ();

    change_dispenser #(
        .GAP_CYCLES  (GAP),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) until the coin request level equals 'level'; n = negedges waited.
    task automatic wait_level(input logic level, input int limit, output int n);
        n = 0;
        while (((bus.coin_a | bus.coin_m) !== level) && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // ack_mode: -1 = ack held high throughout, -2 = random ack delay per coin, >=0 fixed delay.
    task automatic run_seq(input logic [2:0] amt, input int ack_mode, input bit poke);
        int  r;
        int  n;
        int  d;
        int  hold;
        int  exp_hold;
        bit  exp_a;
        bit  first;
        bit  const_ack;
        const_ack = (ack_mode == -1);
        @(negedge clk);
        bus.refund = 1'b1;
        bus.amount = amt;
        bus.hopper_ack = const_ack;
        @(negedge clk);
        bus.refund = 1'b0;
        bus.amount = 3'($urandom_range(0, 7));
        if (amt == 3'd0) begin
            @(negedge clk);
            chk("zero_done", bus.done, 1);
            chk("zero_busy", bus.busy, 0);
            chk("zero_coins", {bus.coin_a, bus.coin_m}, 0);
            @(negedge clk);
            chk("zero_done_pulse", bus.done, 0);
            chk("zero_coins_after", {bus.coin_a, bus.coin_m, bus.busy}, 0);
            bus.hopper_ack = 1'b0;
            $display("txn amount=0 -> done only");
            return;
        end
        r = amt;
        first = 1'b1;
        while (r != 0) begin
            exp_a = (r >= 2);
            wait_level(1'b1, 20, n);
            chk(first ? "first_latency" : "gap_len", n, first ? 1 : GAP);
            chk("coin_a", bus.coin_a, exp_a);
            chk("coin_m", bus.coin_m, !exp_a);
            chk("rem_at_req", bus.remaining, r);
            chk("busy_in_req", bus.busy, 1);
            if (const_ack) begin
                d = -1;
            end else if (ack_mode == -2) begin
                d = $urandom_range(0, 3);
            end else begin
                d = ack_mode;
            end
            exp_hold = d + 2;
            hold = 0;
            while ((bus.coin_a | bus.coin_m) && hold < 40) begin
                if (!const_ack && hold == d) bus.hopper_ack = 1'b1;
                if (poke && first && hold == 1) begin
                    bus.refund = 1'b1;
                    bus.amount = 3'd7;
                end else begin
                    bus.refund = 1'b0;
                end
                @(negedge clk);
                hold++;
            end
            bus.refund = 1'b0;
            if (!const_ack) bus.hopper_ack = 1'b0;
            chk("hold_len", hold, exp_hold);
            r = r - (exp_a ? 2 : 1);
            chk("rem_after_ack", bus.remaining, r);
            chk("busy_after_ack", bus.busy, (r != 0));
            chk("done_after_ack", bus.done, (r == 0));
            $display("txn amount=%0d coin=%s hold=%0d remaining=%0d", amt, exp_a ? "a" : "m", hold, bus.remaining);
            first = 1'b0;
        end
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
        bus.hopper_ack = 1'b0;
    endtask

    initial begin
        int n;
        int falls;
        int hi;
        int bad;
        logic prev;
        reset = 1'b1;
        bus.refund = 1'b0;
        bus.amount = 3'd0;
        bus.hopper_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_coin_a", bus.coin_a, 0);
        chk("rst_coin_m", bus.coin_m, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_remaining", bus.remaining, 0);
        chk("rst_err", bus.err, 0);
        reset = 1'b0;
        @(negedge clk);

        // amount 5 with constant ack: a, a, m
        run_seq(3'd5, -1, 1'b0);
        // amount 0: only a done pulse
        run_seq(3'd0, -1, 1'b0);
        // amount 1, ack first sampled 3 edges after coin_m rises; refund 7 during busy
        run_seq(3'd1, 2, 1'b1);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.coin_a !== 1'b0 || bus.coin_m !== 1'b0) bad++;
        end
        chk("refund_during_busy_ignored", bad, 0);

        // amount 7, reset after second a coin
        bus.hopper_ack = 1'b1;
        @(negedge clk);
        bus.refund = 1'b1;
        bus.amount = 3'd7;
        @(negedge clk);
        bus.refund = 1'b0;
        falls = 0;
        prev = 1'b0;
        n = 0;
        while (falls < 2 && n < 60) begin
            @(negedge clk);
            n++;
            if (prev && !bus.coin_a) falls++;
            prev = bus.coin_a;
        end
        chk("two_a_before_reset", falls, 2);
        chk("rem_before_reset", bus.remaining, 3);
        reset = 1'b1;
        bus.hopper_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_outputs", {bus.coin_a, bus.coin_m, bus.busy, bus.done, bus.remaining, bus.err}, 0);
        bad = 0;
        repeat (GAP + 3) begin
            @(negedge clk);
            if ((bus.coin_a | bus.coin_m | bus.busy) !== 1'b0) bad++;
        end
        chk("midrst_no_resume", bad, 0);
        $display("txn amount=7 abandoned by reset");
        run_seq(3'd2, -1, 1'b0);

`ifdef CHANGE_TIMEOUT_EN
        bus.hopper_ack = 1'b0;
        @(negedge clk);
        bus.refund = 1'b1;
        bus.amount = 3'd3;
        @(negedge clk);
        bus.refund = 1'b0;
        wait_level(1'b1, 20, n);
        chk("to_first_latency", n, 1);
        chk("to_coin_a", bus.coin_a, 1);
        wait_level(1'b0, 40, n);
        chk("to_hold", n, TO);
        chk("to_err", bus.err, 1);
        chk("to_busy", bus.busy, 0);
        chk("to_remaining", bus.remaining, 3);
        bus.refund = 1'b1;
        bus.amount = 3'd2;
        bus.hopper_ack = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            bus.refund = 1'b0;
            if (bus.coin_a !== 1'b0 || bus.coin_m !== 1'b0 || bus.err !== 1'b1 || bus.remaining !== 3'd3) bad++;
        end
        chk("err_sticky", bad, 0);
        bus.hopper_ack = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("err_cleared", bus.err, 0);
        $display("txn amount=3 ack timeout -> err");
`else
        bus.hopper_ack = 1'b0;
        @(negedge clk);
        bus.refund = 1'b1;
        bus.amount = 3'd3;
        @(negedge clk);
        bus.refund = 1'b0;
        wait_level(1'b1, 20, n);
        chk("wait_first_latency", n, 1);
        hi = 0;
        bad = 0;
        repeat (300) begin
            if (bus.coin_a === 1'b1) hi++;
            if (bus.err !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("wait_coin_a_held", hi, 300);
        chk("wait_err_zero", bad, 0);
        bus.hopper_ack = 1'b1;
        wait_level(1'b0, 10, n);
        chk("wait_ack_fall", n, 2);
        bus.hopper_ack = 1'b0;
        chk("wait_rem_after", bus.remaining, 1);
        wait_level(1'b1, 20, n);
        chk("wait_gap", n, GAP);
        chk("wait_coin_m", bus.coin_m, 1);
        bus.hopper_ack = 1'b1;
        wait_level(1'b0, 10, n);
        chk("wait_m_fall", n, 2);
        chk("wait_done", bus.done, 1);
        bus.hopper_ack = 1'b0;
        @(negedge clk);
        $display("txn amount=3 long wait then resumed");
`endif

        for (int i = 0; i < 10; i++) begin
            run_seq(3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 0) ? -1 : -2, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
